uwb_spi_master: RTL and testbench

Byte-stream SPI master between the UWB packet writer and the UWB radio. It consumes a stream of framing commands and payload bytes on a valid/ready input:
- The first byte of each frame is a length N.
- The next N bytes are shifted out MSB-first on SPI mode 0, with chip-select held low for the whole frame.

Each byte clocked in on MISO during a frame is returned on a one-cycle strobe. The block runs entirely on one clock and generates SCK by division.

---
 rtl/uwb_spi_master.sv | 149 ++++++++++++++
 tb/tb_uwb_spi_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uwb_spi_master.sv
// Byte-stream SPI master (mode 0): a length byte opens a frame, the next N bytes are
// shifted out MSB-first under one chip-select, and every MISO byte comes back on a strobe.
module uwb_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GUARD = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]    r_state;
  logic [DW-1:0] r_div;
  logic [GW-1:0] r_gap;
  logic [2:0]    r_bit;
  logic [7:0]    r_rem;
  logic [7:0]    r_tx_sh;
  logic [7:0]    r_rx_sh;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_busy;
  logic          r_cs_n;
  logic          r_sck;
  logic          r_mosi;

  logic          w_accept;
  logic          w_div_end;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_WAIT);
  assign w_accept  = in_valid && in_ready;
  assign w_div_end = (r_div == DIV_LAST);

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
  assign spi_cs_n = r_cs_n;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_gap      <= '0;
      r_bit      <= '0;
      r_rem      <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A zero length byte is swallowed without touching the bus.
          if (w_accept && (in_data != 8'd0)) begin
            r_rem   <= in_data;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_accept) begin
            r_tx_sh <= in_data;
            r_mosi  <= in_data[7];
            r_bit   <= '0;
            r_div   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_div_end) begin
            r_div <= '0;
            if (!r_sck) begin
              r_sck <= 1'b1;
            end else begin
              // End of high phase: sample MISO, drop SCK and advance MOSI on the same edge.
              r_sck   <= 1'b0;
              r_rx_sh <= {r_rx_sh[6:0], spi_miso};
              if (r_bit == 3'd7) begin
                r_rx_data  <= {r_rx_sh[6:0], spi_miso};
                r_rx_valid <= 1'b1;
                r_mosi     <= 1'b0;
                r_rem      <= r_rem - 8'd1;
                r_state    <= (r_rem == 8'd1) ? S_GUARD : S_WAIT;
              end else begin
                r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                r_mosi  <= r_tx_sh[6];
                r_bit   <= r_bit + 3'd1;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_GUARD: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_gap   <= '0;
            r_cs_n  <= 1'b1;
            r_state <= S_GAP;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_cs_n  <= 1'b1;
          r_sck   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uwb_spi_master.sv
// Directed and randomized bench for uwb_spi_master at CLK_DIV=1 and CLK_DIV=4, with an
// SPI slave model and frame-level expectations computed from the byte/timing rules.
module tb_uwb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       sel = 1'b0;
  logic       loop = 1'b0;
  logic       s_miso = 1'b0;
  logic       miso;

  logic       rdy1, rxv1, busy1, cs1, sck1, mo1;
  logic       rdy4, rxv4, busy4, cs4, sck4, mo4;
  logic [7:0] rxd1, rxd4;

  logic       m_rdy, m_rxv, m_busy, m_cs_n, m_sck, m_mosi;
  logic [7:0] m_rxd;

  assign m_rdy  = sel ? rdy4  : rdy1;
  assign m_rxv  = sel ? rxv4  : rxv1;
  assign m_busy = sel ? busy4 : busy1;
  assign m_cs_n = sel ? cs4   : cs1;
  assign m_sck  = sel ? sck4  : sck1;
  assign m_mosi = sel ? mo4   : mo1;
  assign m_rxd  = sel ? rxd4  : rxd1;
  assign miso   = loop ? m_mosi : s_miso;

  always #5 clk = ~clk;

  uwb_spi_master #(.CLK_DIV(1), .CS_GAP(2)) u_d1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1), .spi_cs_n(cs1), .spi_sck(sck1),
    .spi_mosi(mo1), .spi_miso(miso)
  );

  uwb_spi_master #(.CLK_DIV(4), .CS_GAP(2)) u_d4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy4),
    .rx_data(rxd4), .rx_valid(rxv4), .busy(busy4), .spi_cs_n(cs4), .spi_sck(sck4),
    .spi_mosi(mo4), .spi_miso(miso)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] pay   [0:255];
  logic [7:0] s_arr [0:255];

  // Mode-0 slave: shifts its byte out on SCK low, captures MOSI on SCK rise.
  logic [7:0] mosi_seen [$];
  int         s_idx = 0;
  int         s_bit = 0;
  logic [7:0] s_rx = 8'h00;
  logic       s_psck = 1'b0;

  always @(m_cs_n or m_sck or rst) begin
    if (rst) begin
      s_idx  = 0;
      s_bit  = 0;
      s_miso = 1'b0;
      mosi_seen.delete();
    end else if (!m_cs_n) begin
      if (m_sck && !s_psck) begin
        s_rx = {s_rx[6:0], m_mosi};
        s_bit++;
        if (s_bit == 8) begin
          mosi_seen.push_back(s_rx);
          s_idx++;
          s_bit = 0;
        end
      end
      if (!m_sck) s_miso = s_arr[s_idx & 255][7 - s_bit];
    end
    s_psck = m_sck;
  end

  logic [7:0] rx_seen [$];
  int         cs_lens [$];
  int         gaps [$];
  int         his [$];
  int         rises = 0;
  int         cs_cnt = 0, gap_cnt = 0, hi_cnt = 0;
  bit         gap_run = 0, hi_run = 0;
  logic       prev_cs = 1'b1, prev_sck = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      rx_seen.delete(); cs_lens.delete(); gaps.delete(); his.delete();
      rises = 0; cs_cnt = 0; gap_cnt = 0; hi_cnt = 0;
      gap_run = 0; hi_run = 0; prev_cs = 1'b1; prev_sck = 1'b0;
    end else begin
      if (m_rxv) rx_seen.push_back(m_rxd);
      if (m_sck && !prev_sck) rises++;
      if (m_cs_n && !prev_cs) begin
        cs_lens.push_back(cs_cnt);
        cs_cnt = 0; gap_run = 1; gap_cnt = 0; hi_run = 1; hi_cnt = 0;
      end
      if (!m_cs_n) cs_cnt++;
      if (gap_run) begin
        if (!m_rdy) gap_cnt++;
        else begin gaps.push_back(gap_cnt); gap_run = 0; end
      end
      if (hi_run) begin
        if (m_cs_n) hi_cnt++;
        else begin his.push_back(hi_cnt); hi_run = 0; end
      end
      prev_cs  = m_cs_n;
      prev_sck = m_sck;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bound(input string tag, input int n, input int lim);
    tests++;
    assert (n < lim) else begin
      fails++;
      $error("FAIL %s: waited %0d cycles, limit %0d", tag, n, lim);
    end
  endtask

  function automatic int cs_expect(input int n, input int d);
    return n * (16 * d + 1) + d;
  endfunction

  task automatic reset_dut(input logic s);
    in_valid = 1'b0;
    rst = 1'b1;
    loop = 1'b0;
    #1 sel = s;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; the following posedge accepts once in_ready is seen high.
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!m_rdy && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) check_bound("handshake", n, 5000);
    @(negedge clk);
  endtask

  task automatic frame(input int n, input int base);
    send(8'(n));
    for (int i = 0; i < n; i++) send(pay[base + i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    in_valid = 1'b0;
    while (m_busy && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) check_bound("idle_wait", n, 20000);
    repeat (2) @(negedge clk);
  endtask

  task automatic verify(input string tag, input int n, input bit lp);
    check($sformatf("%s_ntx", tag), mosi_seen.size(), n);
    check($sformatf("%s_nrx", tag), rx_seen.size(), n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_tx%0d", tag, i), mosi_seen[i], pay[i]);
      check($sformatf("%s_rx%0d", tag, i), rx_seen[i], lp ? pay[i] : s_arr[i]);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int lens [3];
    bit bad_cs, bad_sck, bad_rdy, bad_busy, bad_rxv;

    // Reset state and the basic two-byte frame at CLK_DIV=1.
    reset_dut(1'b0);
    check("rst_cs_n", m_cs_n, 1);
    check("rst_sck", m_sck, 0);
    check("rst_mosi", m_mosi, 0);
    check("rst_rxv", m_rxv, 0);
    check("rst_rxd", m_rxd, 0);
    check("rst_busy", m_busy, 0);
    check("rst_rdy", m_rdy, 1);
    pay[0] = 8'h5F; pay[1] = 8'h10;
    s_arr[0] = 8'hA5; s_arr[1] = 8'h3C;
    frame(2, 0);
    wait_idle();
    verify("t1", 2, 1'b0);
    check("t1_ncs", cs_lens.size(), 1);
    check("t1_cslen", cs_lens[0], cs_expect(2, 1));
    check("t1_rises", rises, 16);

    // Zero length byte is consumed silently; the next byte opens a real frame.
    reset_dut(1'b0);
    in_data = 8'h00; in_valid = 1'b1;
    check("t2_rdy", m_rdy, 1);
    @(negedge clk);
    in_valid = 1'b0;
    bad_cs = 0; bad_sck = 0; bad_busy = 0; bad_rxv = 0;
    repeat (10) begin
      if (!m_cs_n) bad_cs = 1;
      if (m_sck) bad_sck = 1;
      if (m_busy) bad_busy = 1;
      if (m_rxv) bad_rxv = 1;
      @(negedge clk);
    end
    check("t2_cs_quiet", bad_cs, 0);
    check("t2_sck_quiet", bad_sck, 0);
    check("t2_busy_quiet", bad_busy, 0);
    check("t2_rxv_quiet", bad_rxv, 0);
    pay[0] = 8'h77; s_arr[0] = 8'($urandom);
    frame(1, 0);
    wait_idle();
    verify("t2", 1, 1'b0);
    check("t2_cslen", cs_lens[0], cs_expect(1, 1));

    // Upstream stall inside a frame.
    reset_dut(1'b0);
    for (int i = 0; i < 3; i++) begin pay[i] = 8'($urandom); s_arr[i] = 8'($urandom); end
    send(8'd3);
    send(pay[0]);
    in_valid = 1'b0;
    n = 0;
    while (rx_seen.size() < 1 && n < 1000) begin @(negedge clk); n++; end
    check_bound("t3_first_rx", n, 1000);
    bad_cs = 0; bad_sck = 0; bad_rdy = 0; bad_busy = 0;
    repeat (20) begin
      if (m_cs_n) bad_cs = 1;
      if (m_sck) bad_sck = 1;
      if (!m_rdy) bad_rdy = 1;
      if (!m_busy) bad_busy = 1;
      @(negedge clk);
    end
    check("t3_cs_held", bad_cs, 0);
    check("t3_sck_held", bad_sck, 0);
    check("t3_rdy_held", bad_rdy, 0);
    check("t3_busy_held", bad_busy, 0);
    send(pay[1]);
    send(pay[2]);
    wait_idle();
    verify("t3", 3, 1'b0);
    check("t3_rises", rises, 24);

    // Long frame with MISO looped back from MOSI.
    reset_dut(1'b0);
    loop = 1'b1;
    for (int i = 0; i < 65; i++) pay[i] = 8'(i);
    frame(65, 0);
    wait_idle();
    verify("t4", 65, 1'b1);
    check("t4_cslen", cs_lens[0], cs_expect(65, 1));
    loop = 1'b0;

    // Back-to-back single-byte frames at CLK_DIV=4: inter-frame gap.
    reset_dut(1'b1);
    for (int i = 0; i < 2; i++) begin pay[i] = 8'($urandom); s_arr[i] = 8'($urandom); end
    send(8'd1);
    send(pay[0]);
    send(8'd1);
    send(pay[1]);
    wait_idle();
    verify("t5", 2, 1'b0);
    check("t5_ncs", cs_lens.size(), 2);
    check("t5_cslen0", cs_lens[0], cs_expect(1, 4));
    check("t5_cslen1", cs_lens[1], cs_expect(1, 4));
    check("t5_gap", gaps[0], 2);
    check("t5_cs_high", his[0], 3);

    // Randomized frames at CLK_DIV=4.
    reset_dut(1'b1);
    base = 0;
    for (int f = 0; f < 3; f++) begin
      lens[f] = int'($urandom_range(1, 4));
      for (int i = 0; i < lens[f]; i++) begin
        pay[base + i]   = 8'($urandom);
        s_arr[base + i] = 8'($urandom);
      end
      base += lens[f];
    end
    base = 0;
    for (int f = 0; f < 3; f++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      frame(lens[f], base);
      base += lens[f];
    end
    wait_idle();
    verify("t6", base, 1'b0);
    check("t6_ncs", cs_lens.size(), 3);
    for (int f = 0; f < 3; f++)
      check($sformatf("t6_cslen%0d", f), cs_lens[f], cs_expect(lens[f], 4));

    // Asynchronous reset in the middle of a byte, then a clean frame.
    reset_dut(1'b1);
    pay[0] = 8'($urandom); s_arr[0] = 8'($urandom);
    send(8'd1);
    send(pay[0]);
    in_valid = 1'b0;
    n = 0;
    while (!(rises >= 3 && !m_sck) && n < 1000) begin @(negedge clk); n++; end
    check_bound("t7_three_bits", n, 1000);
    #1 rst = 1'b1;
    #1;
    check("t7_cs_async", m_cs_n, 1);
    check("t7_sck_async", m_sck, 0);
    check("t7_rxv_async", m_rxv, 0);
    check("t7_busy_async", m_busy, 0);
    check("t7_no_rx", rx_seen.size(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t7_rxd_cleared", m_rxd, 0);
    pay[0] = 8'hC3; s_arr[0] = 8'($urandom);
    frame(1, 0);
    wait_idle();
    verify("t7", 1, 1'b0);
    check("t7_cslen", cs_lens[0], cs_expect(1, 4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
